pll_lock_sequencer: RTL and testbench
=====================================

Name: pll_lock_sequencer

Overview:
- Sequences the PLL wrapper's reset and lock handshake.
- Holds the PLL in reset for a fixed time, waits for lock with a timeout, and requires lock to stay stable before releasing the downstream system reset.
- On loss of lock, or on software request, re-runs the sequence; declares failure after bounded retries.
- Sits between board reset and the fabric running from the PLL output; clocked by the PLL reference clock.

Parameters:
RST_HOLD_CYCLES, 16, cycles pll_rst is held high per attempt (>=2)
LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before release (>=2)
LOCK_TIMEOUT_CYCLES, 65536, max cycles in WAIT_LOCK before an attempt fails (>=2)
MAX_RETRIES, 3, timeouts tolerated before FAIL (1..15)
CNT_W, 17, shared cycle counter width; must hold max(RST_HOLD, LOCK_STABLE, LOCK_TIMEOUT)-1

Ports:
refclk  in  1  reference clock, same net as the PLL refclk
rst_n  in  1  synchronous, active-low reset (sampled on refclk rising edge)
pll_locked  in  1  PLL locked output, asynchronous to refclk
relock_req  in  1  single-cycle pulse forcing a full re-lock
pll_rst  out  1  to PLL rst, active high
sys_rst_n  out  1  downstream reset, active low, high only in RUN
fail  out  1  sticky: retries exhausted
retry_cnt  out  4  timeouts in current sequence
state  out  3  encoded FSM state for status/debug

Behaviour:
- Reset (rst_n=0 at an edge): state=RESET_HOLD, pll_rst=1, sys_rst_n=0, fail=0, retry_cnt=0, counter=0, lock sync flops=0. Reset mid-sequence aborts immediately, regardless of state.
- pll_locked passes through a 2-flop synchronizer to give lock_s. Only lock_s is used. All outputs are registered.
- State encoding: RESET_HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, LOST=4, FAIL=5.
- Priority: rst_n > relock_req > lock/counter events.
- RESET_HOLD: pll_rst=1. Counter increments; at RST_HOLD_CYCLES-1, go to WAIT_LOCK with counter=0.
- WAIT_LOCK: pll_rst=0.
  - If lock_s=1, go to STABLE with counter=0.
  - Else, when counter reaches LOCK_TIMEOUT_CYCLES-1:
    - If retry_cnt==MAX_RETRIES, go to FAIL.
    - Else retry_cnt+1 and go to RESET_HOLD.
- STABLE:
  - If lock_s=0 (glitch), go to WAIT_LOCK with counter=0; retry_cnt unchanged.
  - When counter reaches LOCK_STABLE_CYCLES-1 with lock_s=1, go to RUN.
- RUN: sys_rst_n=1, retry_cnt cleared to 0.
  - If lock_s=0, go to LOST.
- LOST: sys_rst_n=0, pll_rst=0. Lasts exactly one cycle, then RESET_HOLD.
- FAIL: pll_rst=1, sys_rst_n=0, fail=1. Exits only on rst_n or relock_req.
- relock_req=1 in any state: go to RESET_HOLD, counter=0, retry_cnt=0, fail=0, sys_rst_n=0 on the same edge.
- relock_req during RESET_HOLD restarts the hold count.
- Timing:
  - pll_rst rises on the edge entering RESET_HOLD.
  - With edge 0 = first edge sampling pll_locked=1 in WAIT_LOCK, STABLE is entered at edge 2 and RUN (sys_rst_n=1) at edge LOCK_STABLE_CYCLES+2.
  - If lock_s falls at edge k in RUN, sys_rst_n=0 at edge k+1 and pll_rst=1 at edge k+2.
- Counter never wraps; it is cleared on every state change.

Optional Feature:
- Macro: PLL_SEQ_LOSS_CNT_EN.
- When defined, adds output lock_loss_cnt[7:0].
  - Increments on each RUN->LOST transition.
  - Saturates at 255.
  - Cleared only by rst_n; relock_req does not clear it.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
All cases use RST_HOLD_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
1. Clean lock: release rst_n, pll_locked=1 from cycle 10 -> pll_rst high exactly 4 cycles; sys_rst_n rises 10 edges after first sample of locked; state=3; fail=0; retry_cnt=0.
2. Lock glitch: locked high, dropped for 1 cycle after 5 cycles in STABLE, then high -> STABLE->WAIT_LOCK->STABLE; sys_rst_n stays 0 until 8 further stable cycles complete; retry_cnt=0.
3. Timeout/FAIL: pll_locked held 0 -> retry_cnt steps 1, 2; on the third timeout state=5, fail=1, pll_rst=1, sys_rst_n=0 held for 200 cycles; relock_req pulse -> fail=0, state=0.
4. Loss in RUN: drop locked at edge k -> sys_rst_n=0 at k+1, state=4 at k+1, pll_rst=1 at k+2; restore lock -> returns to RUN; lock_loss_cnt=1 if PLL_SEQ_LOSS_CNT_EN.
5. Priority/reset: assert relock_req and rst_n=0 on the same edge mid-STABLE -> reset wins, all outputs at reset values; then a relock_req pulse in RUN -> sys_rst_n=0 on the next edge, 4-cycle pll_rst, relock.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//
// Runs the PLL reset/lock handshake. The sequencer holds the PLL in reset for a fixed time,
// then waits for lock with a timeout. Lock must stay stable for a set time before the
// downstream system reset is released. On loss of lock or on a software re-lock request,
// the sequence runs again. After a bounded number of lock timeouts it stops in FAIL.
// The block is clocked by the PLL reference clock.
//
// Ports:
//   i_refclk          reference clock (same net as the PLL refclk)
//   i_rst_n           synchronous active-low reset
//   i_pll_locked      PLL lock indicator, asynchronous to i_refclk
//   i_relock_req      single-cycle pulse forcing a full re-lock
//   o_pll_rst         PLL reset, active high
//   o_sys_rst_n       downstream reset, active low, high only in RUN
//   o_fail            sticky failure flag, set when retries are exhausted
//   o_retry_cnt       lock timeouts seen in the current sequence
//   o_state           encoded FSM state (0 hold, 1 wait, 2 stable, 3 run, 4 lost, 5 fail)
//   o_lock_loss_cnt   saturating count of RUN->LOST events (only with PLL_SEQ_LOSS_CNT_EN)
//
// Optional feature macro: PLL_SEQ_LOSS_CNT_EN adds o_lock_loss_cnt.

module pll_lock_sequencer #(
    parameter int unsigned RST_HOLD_CYCLES     = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned CNT_W               = 17
) (
    input  logic       i_refclk,
    input  logic       i_rst_n,
    input  logic       i_pll_locked,
    input  logic       i_relock_req,
    output logic       o_pll_rst,
    output logic       o_sys_rst_n,
    output logic       o_fail,
    output logic [3:0] o_retry_cnt,
`ifdef PLL_SEQ_LOSS_CNT_EN
    output logic [7:0] o_lock_loss_cnt,
`endif
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        StResetHold = 3'd0,
        StWaitLock  = 3'd1,
        StStable    = 3'd2,
        StRun       = 3'd3,
        StLost      = 3'd4,
        StFail      = 3'd5
    } state_e;

    localparam logic [CNT_W-1:0] RstHoldLast = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       MaxRetries  = 4'(MAX_RETRIES);

    logic             r_lock_meta;
    logic             r_lock_s;
    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_retry_cnt;
    logic             r_pll_rst;
    logic             r_sys_rst_n;
    logic             r_fail;

    state_e           w_state_d;
    logic [CNT_W-1:0] w_cnt_d;
    logic [3:0]       w_retry_d;
    logic             w_pll_rst_d;
    logic             w_sys_rst_n_d;
    logic             w_fail_d;

    // State register, lock synchronizer and registered outputs.
    always_ff @(posedge i_refclk) begin
        if (!i_rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
            r_state     <= StResetHold;
            r_cnt       <= '0;
            r_retry_cnt <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_lock_meta <= i_pll_locked;
            r_lock_s    <= r_lock_meta;
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_retry_cnt <= w_retry_d;
            r_pll_rst   <= w_pll_rst_d;
            r_sys_rst_n <= w_sys_rst_n_d;
            r_fail      <= w_fail_d;
        end
    end

    // Next-state, counter and retry logic.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_retry_d = r_retry_cnt;
        if (i_relock_req) begin
            w_state_d = StResetHold;
            w_retry_d = '0;
        end else begin
            unique case (r_state)
                StResetHold: begin
                    if (r_cnt == RstHoldLast) w_state_d = StWaitLock;
                    else                      w_cnt_d   = r_cnt + 1'b1;
                end
                StWaitLock: begin
                    // Lock wins over a timeout landing on the same cycle.
                    if (r_lock_s) begin
                        w_state_d = StStable;
                    end else if (r_cnt == TimeoutLast) begin
                        if (r_retry_cnt == MaxRetries) begin
                            w_state_d = StFail;
                        end else begin
                            w_retry_d = r_retry_cnt + 4'd1;
                            w_state_d = StResetHold;
                        end
                    end else begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
                StStable: begin
                    if (!r_lock_s)                w_state_d = StWaitLock;
                    else if (r_cnt == StableLast) w_state_d = StRun;
                    else                          w_cnt_d   = r_cnt + 1'b1;
                end
                StRun: begin
                    if (!r_lock_s) w_state_d = StLost;
                end
                StLost:  w_state_d = StResetHold;
                StFail:  w_state_d = StFail;
                default: w_state_d = StResetHold;
            endcase
        end
        // Relock always restarts the hold count, even from inside RESET_HOLD.
        if (i_relock_req || (w_state_d != r_state)) w_cnt_d = '0;
        if (w_state_d == StRun) w_retry_d = '0;
    end

    // Output decode from the next state, so the registered outputs track r_state exactly.
    always_comb begin
        w_pll_rst_d   = 1'b0;
        w_sys_rst_n_d = 1'b0;
        w_fail_d      = 1'b0;
        unique case (w_state_d)
            StResetHold: w_pll_rst_d = 1'b1;
            StRun:       w_sys_rst_n_d = 1'b1;
            StFail: begin
                w_pll_rst_d = 1'b1;
                w_fail_d    = 1'b1;
            end
            default: begin
                w_pll_rst_d   = 1'b0;
                w_sys_rst_n_d = 1'b0;
                w_fail_d      = 1'b0;
            end
        endcase
    end

`ifdef PLL_SEQ_LOSS_CNT_EN
    logic [7:0] r_loss_cnt;
    logic       w_loss_inc;

    // Only a real RUN->LOST step counts; relock is not a loss and never clears the count.
    assign w_loss_inc = (r_state == StRun) && (w_state_d == StLost) && (r_loss_cnt != 8'hFF);

    always_ff @(posedge i_refclk) begin
        if (!i_rst_n)        r_loss_cnt <= '0;
        else if (w_loss_inc) r_loss_cnt <= r_loss_cnt + 8'd1;
    end

    assign o_lock_loss_cnt = r_loss_cnt;
`endif

    assign o_pll_rst   = r_pll_rst;
    assign o_sys_rst_n = r_sys_rst_n;
    assign o_fail      = r_fail;
    assign o_retry_cnt = r_retry_cnt;
    assign o_state     = r_state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed testbench for pll_lock_sequencer with small timing parameters.
module tb_pll_lock_sequencer;

    localparam int unsigned RH = 4;
    localparam int unsigned LS = 8;
    localparam int unsigned LT = 32;
    localparam int unsigned MR = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       locked;
    logic       relock;
    logic       o_pll_rst;
    logic       o_sys_rst_n;
    logic       o_fail;
    logic [3:0] o_retry_cnt;
    logic [2:0] o_state;
`ifdef PLL_SEQ_LOSS_CNT_EN
    logic [7:0] o_lock_loss_cnt;
`endif

    logic [9:0] obs;
    logic [9:0] exp;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    pll_lock_sequencer #(
        .RST_HOLD_CYCLES    (RH),
        .LOCK_STABLE_CYCLES (LS),
        .LOCK_TIMEOUT_CYCLES(LT),
        .MAX_RETRIES        (MR),
        .CNT_W              (6)
    ) dut (
        .i_refclk       (clk),
        .i_rst_n        (rst_n),
        .i_pll_locked   (locked),
        .i_relock_req   (relock),
        .o_pll_rst      (o_pll_rst),
        .o_sys_rst_n    (o_sys_rst_n),
        .o_fail         (o_fail),
        .o_retry_cnt    (o_retry_cnt),
`ifdef PLL_SEQ_LOSS_CNT_EN
        .o_lock_loss_cnt(o_lock_loss_cnt),
`endif
        .o_state        (o_state)
    );

    // {state, pll_rst, sys_rst_n, fail, retry_cnt}
    assign obs = {o_state, o_pll_rst, o_sys_rst_n, o_fail, o_retry_cnt};

    function automatic logic [9:0] pk(input logic [2:0] s, input logic pr, input logic sr,
                                      input logic f, input logic [3:0] rc);
        return {s, pr, sr, f, rc};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        locked = 1'b0;
        relock = 1'b0;
        rst_n  = 1'b0;
        tick(3);
        exp = pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_values: got %b want %b", obs, exp);
        end
`ifdef PLL_SEQ_LOSS_CNT_EN
        checks++;
        if (o_lock_loss_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_loss_cnt: got %0d want 0", o_lock_loss_cnt);
        end
`endif
    endtask

    task automatic test_clean_lock;
        rst_n = 1'b1;
        tick(1);
        exp = pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL clean_hold_r0: got %b want %b", obs, exp);
        end
        tick(2);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL clean_hold_r2: got %b want %b", obs, exp);
        end
        tick(1);
        exp = pk(3'd1, 1'b0, 1'b0, 1'b0, 4'd0);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL clean_hold_end: got %b want %b", obs, exp);
        end
        tick(6);
        locked = 1'b1;
        for (int e = 0; e <= 10; e++) begin
            logic [2:0] st;
            tick(1);
            st  = (e < 2) ? 3'd1 : ((e < 10) ? 3'd2 : 3'd3);
            exp = pk(st, 1'b0, (st == 3'd3), 1'b0, 4'd0);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL clean_lock_edge%0d: got %b want %b", e, obs, exp);
            end
        end
    endtask

    task automatic test_glitch;
        locked = 1'b0;
        rst_n  = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        locked = 1'b1;
        tick(3);
        exp = pk(3'd2, 1'b0, 1'b0, 1'b0, 4'd0);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL glitch_enter_stable: got %b want %b", obs, exp);
        end
        tick(4);
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        for (int e = 8; e <= 18; e++) begin
            logic [2:0] st;
            tick(1);
            st  = (e < 9) ? 3'd2 : ((e == 9) ? 3'd1 : ((e < 18) ? 3'd2 : 3'd3));
            exp = pk(st, 1'b0, (st == 3'd3), 1'b0, 4'd0);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL glitch_edge%0d: got %b want %b", e, obs, exp);
            end
        end
    endtask

    task automatic test_timeout_fail;
        logic bad;
        locked = 1'b0;
        rst_n  = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        for (int a = 0; a <= 2; a++) begin
            exp = pk(3'd1, 1'b0, 1'b0, 1'b0, 4'(a));
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL timeout_wait_start%0d: got %b want %b", a, obs, exp);
            end
            tick(31);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL timeout_wait_last%0d: got %b want %b", a, obs, exp);
            end
            tick(1);
            if (a < 2) begin
                exp = pk(3'd0, 1'b1, 1'b0, 1'b0, 4'(a + 1));
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL timeout_retry%0d: got %b want %b", a, obs, exp);
                end
                tick(4);
            end
        end
        exp = pk(3'd5, 1'b1, 1'b0, 1'b1, 4'd2);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL timeout_fail_entry: got %b want %b", obs, exp);
        end
        bad = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (obs !== exp) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL fail_hold_200: got last %b want %b every cycle", obs, exp);
        end
        relock = 1'b1;
        tick(1);
        relock = 1'b0;
        exp = pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL fail_relock_exit: got %b want %b", obs, exp);
        end
    endtask

    task automatic test_loss_in_run;
        int n;
        locked = 1'b1;
        rst_n  = 1'b0;
        tick(2);
        rst_n = 1'b1;
        n = 0;
        while (o_state !== 3'd3 && n < 40) begin
            tick(1);
            n++;
        end
        checks++;
        if (o_state !== 3'd3) begin
            errors++;
            $display("FAIL loss_bringup: state %0d want 3 within 40 cycles", o_state);
        end
        tick(2);
        locked = 1'b0;
        tick(2);
        exp = pk(3'd3, 1'b0, 1'b1, 1'b0, 4'd0);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL loss_edge_k: got %b want %b", obs, exp);
        end
        tick(1);
        exp = pk(3'd4, 1'b0, 1'b0, 1'b0, 4'd0);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL loss_edge_k1: got %b want %b", obs, exp);
        end
        tick(1);
        exp = pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL loss_edge_k2: got %b want %b", obs, exp);
        end
        locked = 1'b1;
        n = 0;
        while (o_state !== 3'd3 && n < 40) begin
            tick(1);
            n++;
        end
        exp = pk(3'd3, 1'b0, 1'b1, 1'b0, 4'd0);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL loss_relock_run: got %b want %b", obs, exp);
        end
`ifdef PLL_SEQ_LOSS_CNT_EN
        checks++;
        if (o_lock_loss_cnt !== 8'd1) begin
            errors++;
            $display("FAIL loss_cnt_one: got %0d want 1", o_lock_loss_cnt);
        end
`endif
    endtask

    task automatic test_priority;
        relock = 1'b1;
        tick(1);
        relock = 1'b0;
        exp = pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL run_relock_edge: got %b want %b", obs, exp);
        end
        tick(3);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL run_relock_hold3: got %b want %b", obs, exp);
        end
        tick(1);
        exp = pk(3'd1, 1'b0, 1'b0, 1'b0, 4'd0);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL run_relock_hold_end: got %b want %b", obs, exp);
        end
`ifdef PLL_SEQ_LOSS_CNT_EN
        checks++;
        if (o_lock_loss_cnt !== 8'd1) begin
            errors++;
            $display("FAIL relock_keeps_loss_cnt: got %0d want 1", o_lock_loss_cnt);
        end
`endif
        tick(1);
        exp = pk(3'd2, 1'b0, 1'b0, 1'b0, 4'd0);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL relock_stable: got %b want %b", obs, exp);
        end
        tick(3);
        rst_n  = 1'b0;
        relock = 1'b1;
        tick(1);
        exp = pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_beats_relock: got %b want %b", obs, exp);
        end
`ifdef PLL_SEQ_LOSS_CNT_EN
        checks++;
        if (o_lock_loss_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_clears_loss_cnt: got %0d want 0", o_lock_loss_cnt);
        end
`endif
        rst_n  = 1'b1;
        relock = 1'b0;
        tick(12);
        exp = pk(3'd2, 1'b0, 1'b0, 1'b0, 4'd0);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL post_reset_stable: got %b want %b", obs, exp);
        end
        tick(1);
        exp = pk(3'd3, 1'b0, 1'b1, 1'b0, 4'd0);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL post_reset_run: got %b want %b", obs, exp);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        locked = 1'b0;
        relock = 1'b0;
        test_reset();
        test_clean_lock();
        test_glitch();
        test_timeout_fail();
        test_loss_in_run();
        test_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
